// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the sequential multiplier
package mult_pkg;

    // Operand width used when an instance does not override WIDTH.
    localparam int DEFAULT_WIDTH = 4;

    // Controller state encoding. 2'd3 is unused and steers back to idle.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_DONE    = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

endpackage

// File: rtl/mult_control.sv
// rtl/mult_control.sv - sequencing FSM and iteration counter for the shift-add multiplier
module mult_control
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         step_last,
    output logic                         load,
    output logic                         shift_en,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t state;
    state_t state_next;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode. Start is only honoured in idle, so a
    // request raised while busy is simply dropped.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (step_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Step counter: cleared on accept, advances once per shift-add step.
    // It reaches at most WIDTH, which always fits in CW bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (shift_en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle unsigned shift-add multiplier datapath
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic                load;
    logic                shift_en;
    logic                step_last;
    logic [CW-1:0]       count;
    logic [WIDTH-1:0]    mcand;
    logic [2*WIDTH-1:0]  p;
    logic [WIDTH:0]      sum;

    mult_control #(
        .WIDTH (WIDTH)
    ) u_control (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .step_last (step_last),
        .load      (load),
        .shift_en  (shift_en),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    // The step now in progress is the final one of this operation.
    assign step_last = (count == CW'(WIDTH - 1));

    // One WIDTH-bit add per step into the upper half; the extra bit keeps the carry.
    always_comb begin
        sum = {1'b0, p[2*WIDTH-1:WIDTH]};
        if (p[0]) begin
            sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end
    end

    // Operand capture on accept, then shift {carry, upper, lower} right each step
    // so the carry lands in the top bit and the consumed multiplier bit drops out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            p     <= '0;
        end else if (load) begin
            mcand <= a;
            p     <= {{WIDTH{1'b0}}, b};
        end else if (shift_en) begin
            p <= {sum, p[WIDTH-1:1]};
        end
    end

    // P only moves between accept and done, so it doubles as the held result.
    assign product = p;

endmodule
